// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle sequencing controller
// and the datapath/memory side. master = controller, slave = datapath.
interface multicycle_ctrl_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       InstrDone;
  logic [3:0] State;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, InstrDone, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, InstrDone, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: walks FETCH/DECODE/execute/writeback and
// decodes datapath controls from the state, stalling on the memory handshake.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (bus.MemReady) state <= DECODE;
        DECODE: begin
          case (bus.Op)
            2'b00:   state <= bus.Funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:   state <= bus.Funct[0] ? MEMRD : MEMWR;
        MEMRD:    if (bus.MemReady) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWR:    if (bus.MemReady) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  assign bus.State = state;

  // Outputs are gated by reset so everything (MemW included) drops the
  // instant reset asserts, without waiting for a clock.
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUOp     = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.InstrDone = 1'b0;
    if (reset) begin
      case (state)
        FETCH: begin
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.MemReady;
          bus.NextPC    = bus.MemReady;
        end
        DECODE: begin
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.InstrDone = (bus.Op == 2'b11);
        end
        MEMADR: begin
          bus.ALUSrcB   = 2'b01;
        end
        MEMRD: begin
          bus.AdrSrc    = 1'b1;
        end
        MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegW      = 1'b1;
          bus.InstrDone = 1'b1;
        end
        MEMWR: begin
          bus.AdrSrc    = 1'b1;
          bus.MemW      = 1'b1;
          bus.InstrDone = bus.MemReady;
        end
        EXECUTER: begin
          bus.ALUOp     = 1'b1;
        end
        EXECUTEI: begin
          bus.ALUSrcB   = 2'b01;
          bus.ALUOp     = 1'b1;
        end
        ALUWB: begin
          // CMP only sets flags; every other data-processing op writes back.
          bus.RegW      = (bus.Funct[4:1] != 4'b1010);
          bus.InstrDone = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcB   = 2'b01;
          bus.ResultSrc = 2'b10;
          bus.Branch    = 1'b1;
          bus.InstrDone = 1'b1;
        end
        default: begin
          bus.IRWrite   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed reset/abort steps plus random
// instruction streams checked against a per-instruction cycle-sequence model.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit mr;
  } cyc_t;

  cyc_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt;

  logic [12:0] outs;
  assign outs = {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                 bus.ALUOp, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.InstrDone};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control outputs for one cycle, straight from the per-state table.
  function automatic logic [12:0] exp_out(input int st, input logic [1:0] op,
                                          input logic [5:0] funct, input bit mr);
    logic       ir, adr, sa, aop, npc, rw, mw, br, dn;
    logic [1:0] sb, rs;
    ir = 0; adr = 0; sa = 0; aop = 0; npc = 0; rw = 0; mw = 0; br = 0; dn = 0;
    sb = 2'b00; rs = 2'b00;
    case (st)
      0: begin sa = 1; sb = 2'b10; rs = 2'b10; ir = mr; npc = mr; end
      1: begin sa = 1; sb = 2'b10; rs = 2'b10; dn = (op == 2'b11); end
      2: begin sb = 2'b01; end
      3: begin adr = 1; end
      4: begin rs = 2'b01; rw = 1; dn = 1; end
      5: begin adr = 1; mw = 1; dn = mr; end
      6: begin aop = 1; end
      7: begin sb = 2'b01; aop = 1; end
      8: begin dn = 1; rw = (funct[4:1] != 4'b1010); end
      9: begin sb = 2'b01; rs = 2'b10; br = 1; dn = 1; end
      default: begin dn = 0; end
    endcase
    return {ir, adr, sa, sb, rs, aop, npc, rw, mw, br, dn};
  endfunction

  // Cycle-by-cycle expected state trace of one instruction with the given
  // fetch and memory wait counts; MemReady is random where it is ignored.
  task automatic build(input logic [1:0] op, input logic [5:0] funct,
                       input int fw, input int mw);
    q.delete();
    repeat (fw) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom)});
    case (op)
      2'b00: begin
        q.push_back('{funct[5] ? 7 : 6, 1'($urandom)});
        q.push_back('{8, 1'($urandom)});
      end
      2'b01: begin
        q.push_back('{2, 1'($urandom)});
        if (funct[0]) begin
          repeat (mw) q.push_back('{3, 1'b0});
          q.push_back('{3, 1'b1});
          q.push_back('{4, 1'($urandom)});
        end else begin
          repeat (mw) q.push_back('{5, 1'b0});
          q.push_back('{5, 1'b1});
        end
      end
      2'b10: q.push_back('{9, 1'($urandom)});
      default: ;
    endcase
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [5:0] funct,
                     input int n, input int exp_done);
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.Op       = op;
      bus.Funct    = funct;
      bus.MemReady = q[i].mr;
      @(negedge clk);
      chk($sformatf("%s c%0d state", name, i), 32'(bus.State), 32'(q[i].st));
      chk($sformatf("%s c%0d outs", name, i), 32'(outs),
          32'(exp_out(q[i].st, op, funct, q[i].mr)));
      if (bus.InstrDone === 1'b1) done_cnt++;
    end
    chk($sformatf("%s done_pulses", name), 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                       input int fw, input int mw);
    build(op, funct, fw, mw);
    run(name, op, funct, q.size(), 1);
  endtask

  task automatic reset_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 bus.MemReady = 1'b1;
      @(negedge clk);
      chk($sformatf("rst c%0d state", i), 32'(bus.State), 32'd0);
      chk($sformatf("rst c%0d outs", i), 32'(outs), 32'd0);
    end
    #2;
    bus.MemReady = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.Op       = 2'b00;
    bus.Funct    = 6'd0;
    bus.MemReady = 1'b1;

    reset_hold(3);

    // Fetch stalled two cycles right out of reset, then an ADD.
    build(2'b00, 6'b001000, 2, 0);
    chk("add_len", 32'(q.size()), 32'd6);
    run("add_stall", 2'b00, 6'b001000, q.size(), 1);

    instr("add", 2'b00, 6'b001000, 0, 0);
    instr("cmpi", 2'b00, 6'b110101, 0, 0);
    instr("slti", 2'b00, 6'b101011, 0, 0);
    instr("cmpr", 2'b00, 6'b010101, 1, 0);
    instr("ldr_w2", 2'b01, 6'b011001, 0, 2);
    instr("str", 2'b01, 6'b011000, 0, 0);
    instr("str_w1", 2'b01, 6'b011000, 1, 1);
    instr("b", 2'b10, 6'b101010, 0, 0);
    instr("undef", 2'b11, 6'b000000, 0, 0);

    // STR interrupted by reset while waiting on memory.
    build(2'b01, 6'b011000, 0, 3);
    run("str_abort", 2'b01, 6'b011000, 5, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort state", 32'(bus.State), 32'd0);
    chk("abort outs", 32'(outs), 32'd0);
    chk("abort memw", 32'(bus.MemW), 32'd0);
    chk("abort done", 32'(bus.InstrDone), 32'd0);
    reset_hold(1);

    for (int k = 0; k < 60; k++) begin
      logic [1:0] op;
      logic [5:0] funct;
      op    = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 2) == 0) funct[4:1] = 4'b1010;
      instr($sformatf("rnd%0d", k), op, funct, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
